// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types plus the limp memory request/response types
package core_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       wen;
        word_t      addr;
        word_t      wdata;
        logic [3:0] wmask;
    } limp_req_t;

    typedef struct packed {
        word_t rdata;
        logic  err;
    } limp_rsp_t;

    localparam int unsigned LIMP_MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        LIMP_IDLE,
        LIMP_WAIT,
        LIMP_RESP
    } limp_state_e;

endpackage

// File: rtl/limp_sram_responder_if.sv
// rtl/limp_sram_responder_if.sv - core memory port: request and response channels
interface limp_sram_responder_if;
    import core_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic       req_wen;
    word_t      req_addr;
    word_t      req_wdata;
    logic [3:0] req_wmask;
    logic       rsp_valid;
    logic       rsp_ready;
    word_t      rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/limp_sram_array.sv
// rtl/limp_sram_array.sv - single-port word SRAM, byte write enables, registered read, no reset
module limp_sram_array
    import core_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [3:0]    wmask,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/limp_sram_responder.sv
// rtl/limp_sram_responder.sv - single-outstanding SRAM responder with fixed response latency
module limp_sram_responder
    import core_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    limp_sram_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4 =
        4'((LATENCY > LIMP_MAX_LATENCY) ? LIMP_MAX_LATENCY : LATENCY);

    limp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;

    limp_req_t   req;
    limp_rsp_t   rsp;
    word_t       offset;
    word_t       arr_rdata;
    logic        addr_err;
    logic        accept;

    assign req = '{wen: bus.req_wen, addr: bus.req_addr,
                   wdata: bus.req_wdata, wmask: bus.req_wmask};

    // BASE_ADDR is aligned to the array size, so offset[1:0] equals the address alignment
    // bits and the wrapping subtraction sends addresses below BASE far out of range.
    assign offset   = req.addr - BASE_ADDR;
    assign addr_err = (offset[1:0] != 2'b00) || (offset[31:AW+2] != '0);
    assign accept   = bus.req_valid && bus.req_ready;

    limp_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (accept && req.wen && !addr_err),
        .re    (accept && !req.wen && !addr_err),
        .wmask (req.wmask),
        .addr  (offset[AW+1:2]),
        .wdata (req.wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LIMP_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        case (state_q)
            LIMP_IDLE: begin
                if (accept) begin
                    err_d = addr_err;
                    rd_d  = !req.wen && !addr_err;
                    if (LAT4 == 4'd0) begin
                        state_d = LIMP_RESP;
                    end else begin
                        state_d = LIMP_WAIT;
                        cnt_d   = LAT4;
                    end
                end
            end
            LIMP_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = LIMP_RESP;
                end
            end
            LIMP_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = LIMP_IDLE;
                end
            end
            default: state_d = LIMP_IDLE;
        endcase
    end

    // The array's read register holds the captured word; rd_q zeroes it for writes and errors.
    assign rsp = '{rdata: (rd_q ? arr_rdata : '0), err: err_q};

    assign bus.req_ready = (state_q == LIMP_IDLE);
    assign bus.rsp_valid = (state_q == LIMP_RESP);
    assign bus.rsp_rdata = rsp.rdata;
    assign bus.rsp_err   = rsp.err;

endmodule
